// File: rtl/mux_21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_21_rr_arbiter
//
// Round-robin arbiter that shares one DATA_W-wide 2:1 mux between two
// requesters. It registers the selected word into a one-entry output buffer
// and presents that buffer downstream.
//
// Handshakes: a word moves across an interface on the rising edge where that
// interface's valid and ready are both high. A requester holds valid and data
// until it sees ready. The output buffer presents out_valid/out_data/out_sel
// until the edge with out_valid & out_ready.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid0  requester 0 has a word on in_data0
//   in_data0   requester 0 word (mux input 0)
//   in_ready0  combinational; requester 0 is granted this cycle
//   in_valid1  requester 1 has a word on in_data1
//   in_data1   requester 1 word (mux input 1)
//   in_ready1  combinational; requester 1 is granted this cycle
//   out_valid  registered; the buffer holds an unconsumed word (FSM state)
//   out_data   registered; the buffered word
//   out_sel    registered; the source channel of out_data
//   out_ready  the consumer accepts out_data this cycle
//   xfer_cnt   registered; completed downstream transfers (wraps)
// -----------------------------------------------------------------------------
module mux_21_rr_arbiter #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid0,
   input  logic [DATA_W-1:0] in_data0,
   output logic              in_ready0,
   input  logic              in_valid1,
   input  logic [DATA_W-1:0] in_data1,
   output logic              in_ready1,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sel,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  xfer_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;
   state_t state_nx;

   logic   last_grant;
   logic   grant;       // channel selected by arbitration
   logic   grant_vld;   // at least one requester is valid
   logic   load_en;     // the buffer can accept a word on this edge
   logic   capture;     // a word is taken from a requester on this edge
   logic   drain;       // the buffered word is consumed on this edge

   // The FSM state is visible directly on out_valid.
   assign out_valid = (state == FULL);

   // rst_n gates load_en so that no requester sees ready while reset is held.
   assign drain   = (state == FULL) && out_ready;
   assign load_en = rst_n && ((state == EMPTY) || out_ready);

   // Arbitration: a lone requester wins outright; on a tie the channel that
   // did not win the last capture is chosen.
   always_comb begin
      grant     = 1'b0;
      grant_vld = 1'b0;
      if (in_valid0 && !in_valid1) begin
         grant     = 1'b0;
         grant_vld = 1'b1;
      end else if (in_valid1 && !in_valid0) begin
         grant     = 1'b1;
         grant_vld = 1'b1;
      end else if (in_valid0 && in_valid1) begin
         grant     = ~last_grant;
         grant_vld = 1'b1;
      end
   end

   assign capture   = load_en && grant_vld;
   assign in_ready0 = capture && !grant;
   assign in_ready1 = capture &&  grant;

   // Next-state logic. A capture on a draining edge keeps the buffer full.
   always_comb begin
      state_nx = state;
      if (capture) begin
         state_nx = FULL;
      end else if (drain) begin
         state_nx = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         out_data   <= '0;
         out_sel    <= 1'b0;
         xfer_cnt   <= '0;
         last_grant <= 1'b1;   // channel 0 wins the first tie
      end else begin
         state <= state_nx;
         if (capture) begin
            out_data   <= grant ? in_data1 : in_data0;
            out_sel    <= grant;
            last_grant <= grant;
         end
         if (drain) begin
            xfer_cnt <= xfer_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_21_rr_arbiter
//
// Table-driven bench for mux_21_rr_arbiter. Each record gives the inputs for
// one cycle, the expected ready outputs while those inputs are applied, and
// the expected registered outputs after the following rising edge.
// Hand-written sequences cover the counter wrap and reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_mux_21_rr_arbiter;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              in_valid0;
   logic [DATA_W-1:0] in_data0;
   logic              in_ready0;
   logic              in_valid1;
   logic [DATA_W-1:0] in_data1;
   logic              in_ready1;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_sel;
   logic              out_ready;
   logic [CNT_W-1:0]  xfer_cnt;

   int checks   = 0;
   int failures = 0;

   mux_21_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid0 (in_valid0),
      .in_data0  (in_data0),
      .in_ready0 (in_ready0),
      .in_valid1 (in_valid1),
      .in_data1  (in_data1),
      .in_ready1 (in_ready1),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   // ---------------------------------------------------------------- clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic              rst_n;
      logic              v0;
      logic [DATA_W-1:0] d0;
      logic              v1;
      logic [DATA_W-1:0] d1;
      logic              ordy;
      logic              exp_r0;
      logic              exp_r1;
      logic              exp_ov;
      logic [DATA_W-1:0] exp_od;
      logic              exp_os;
      logic [CNT_W-1:0]  exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rn, logic v0, logic [3:0] d0, logic v1,
                               logic [3:0] d1, logic ordy, logic r0, logic r1,
                               logic ov, logic [3:0] od, logic os,
                               logic [7:0] cnt);
      vec_t v;
      v.rst_n = rn;  v.v0 = v0;  v.d0 = d0;  v.v1 = v1;  v.d1 = d1;
      v.ordy = ordy; v.exp_r0 = r0; v.exp_r1 = r1; v.exp_ov = ov;
      v.exp_od = od; v.exp_os = os; v.exp_cnt = cnt;
      return v;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp,
                  $time);
      end
   endtask

   task automatic drive(input logic rn, input logic v0, input logic [3:0] d0,
                        input logic v1, input logic [3:0] d1,
                        input logic ordy);
      rst_n     = rn;
      in_valid0 = v0;
      in_data0  = d0;
      in_valid1 = v1;
      in_data1  = d1;
      out_ready = ordy;
   endtask

   task automatic check_ready(input string tag, input logic r0,
                              input logic r1);
      check({tag, ".in_ready0"}, 32'(in_ready0), 32'(r0));
      check({tag, ".in_ready1"}, 32'(in_ready1), 32'(r1));
   endtask

   task automatic check_out(input string tag, input logic ov,
                            input logic [3:0] od, input logic os,
                            input logic [7:0] cnt);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      check({tag, ".out_data"},  32'(out_data),  32'(od));
      check({tag, ".out_sel"},   32'(out_sel),   32'(os));
      check({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(cnt));
   endtask

   // Apply inputs, check readies before the edge, check registers after it.
   task automatic step_vec(input vec_t v, input string tag);
      drive(v.rst_n, v.v0, v.d0, v.v1, v.d1, v.ordy);
      #1;
      check_ready(tag, v.exp_r0, v.exp_r1);
      @(posedge clk);
      #1;
      check_out(tag, v.exp_ov, v.exp_od, v.exp_os, v.exp_cnt);
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      //            rn v0 d0   v1 d1   ordy r0 r1 ov od   os cnt
      // reset held for two edges with requester 0 valid
      vecs.push_back(mk(0, 1, 4'hF, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 8'd0));
      vecs.push_back(mk(0, 1, 4'hF, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 8'd0));
      // first edge after release captures F from channel 0
      vecs.push_back(mk(1, 1, 4'hF, 0, 4'h0, 0, 1, 0, 1, 4'hF, 0, 8'd0));
      // single channel 1 streaming, drain and capture on the same edge
      vecs.push_back(mk(1, 0, 4'h0, 1, 4'hD, 1, 0, 1, 1, 4'hD, 1, 8'd1));
      vecs.push_back(mk(1, 0, 4'h0, 1, 4'hD, 1, 0, 1, 1, 4'hD, 1, 8'd2));
      vecs.push_back(mk(1, 0, 4'h0, 1, 4'hD, 1, 0, 1, 1, 4'hD, 1, 8'd3));
      // contention: last grant was 1, so 0,1,0,1
      vecs.push_back(mk(1, 1, 4'h1, 1, 4'hE, 1, 1, 0, 1, 4'h1, 0, 8'd4));
      vecs.push_back(mk(1, 1, 4'h1, 1, 4'hE, 1, 0, 1, 1, 4'hE, 1, 8'd5));
      vecs.push_back(mk(1, 1, 4'h1, 1, 4'hE, 1, 1, 0, 1, 4'h1, 0, 8'd6));
      vecs.push_back(mk(1, 1, 4'h1, 1, 4'hE, 1, 0, 1, 1, 4'hE, 1, 8'd7));
      // drain only: data/sel hold, buffer empties
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'hE, 1, 8'd8));
      // idle while empty
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'hE, 1, 8'd8));
      // backpressure: load 3 from channel 0, then stall with both valid
      vecs.push_back(mk(1, 1, 4'h3, 0, 4'h0, 0, 1, 0, 1, 4'h3, 0, 8'd8));
      vecs.push_back(mk(1, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 4'h3, 0, 8'd8));
      vecs.push_back(mk(1, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 4'h3, 0, 8'd8));
      vecs.push_back(mk(1, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 4'h3, 0, 8'd8));
      // release: channel 1 is granted next
      vecs.push_back(mk(1, 1, 4'h3, 1, 4'h5, 1, 0, 1, 1, 4'h5, 1, 8'd9));
      // drain, then idle: neither changes last_grant
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h5, 1, 8'd10));
      vecs.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'h5, 1, 8'd10));
      // tie while empty: last grant was 1, so channel 0 wins
      vecs.push_back(mk(1, 1, 4'h6, 1, 4'h9, 0, 1, 0, 1, 4'h6, 0, 8'd10));

      drive(0, 0, 4'h0, 0, 4'h0, 0);

      foreach (vecs[i]) begin
         step_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Counter wrap: channel 0 streams with out_ready high; every edge
      // drains one word. 10 + 245 = 255, then one more edge wraps to 0.
      drive(1, 1, 4'h7, 0, 4'h0, 1);
      repeat (245) @(posedge clk);
      #1;
      check_out("wrap_pre", 1, 4'h7, 0, 8'd255);
      @(posedge clk);
      #1;
      check_out("wrap", 1, 4'h7, 0, 8'd0);

      // Mid-operation reset: buffer A from channel 0, then reset while
      // out_ready is high; no transfer is counted.
      step_vec(mk(1, 1, 4'hA, 0, 4'h0, 1, 1, 0, 1, 4'hA, 0, 8'd1), "mid_load");
      step_vec(mk(1, 1, 4'hA, 1, 4'hB, 1, 0, 1, 1, 4'hB, 1, 8'd2), "mid_load1");
      step_vec(mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 8'd0), "mid_rst");
      // last grant was 1 before reset too, so force a 0 grant first
      // and then check that reset restored the tie-break to channel 0.
      step_vec(mk(1, 1, 4'h4, 0, 4'h0, 0, 1, 0, 1, 4'h4, 0, 8'd0), "post_ld0");
      step_vec(mk(0, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 4'h0, 0, 8'd0), "rst2");
      step_vec(mk(1, 1, 4'h2, 1, 4'hB, 0, 1, 0, 1, 4'h2, 0, 8'd0), "post_tie");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
